// File: rtl/io_gpio_irq_pkg.sv
// Shared register map and edge-select encodings for the GPIO interrupt block.
// The optional input debounce filter is enabled with IO_GPIO_IRQ_DEBOUNCE_EN.
package io_gpio_irq_pkg;

    localparam logic [13:0] ADR_IRQ_EN   = 14'h3F88;
    localparam logic [13:0] ADR_EDGE_SEL = 14'h3F89;
    localparam logic [13:0] ADR_IRQ_STAT = 14'h3F8A;
    localparam logic [13:0] ADR_DEB_CFG  = 14'h3F8B;

    localparam int NUM_PINS = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
        case (mode)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/io_gpio_irq_deb.sv
// One GPIO pin: two-flop synchroniser, optional debounce filter, edge pulses.
// The filter exists only when IO_GPIO_IRQ_DEBOUNCE_EN is defined.
module io_gpio_irq_deb (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin,
`ifdef IO_GPIO_IRQ_DEBOUNCE_EN
    input  logic [7:0] deb_cfg,
`endif
    output logic       rise,
    output logic       fall
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef IO_GPIO_IRQ_DEBOUNCE_EN
    logic [7:0] cnt;

    // Commit on the (deb_cfg+1)-th disagreeing cycle; >= lets a lowered threshold take effect at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= 8'd0;
        end else if (sync2 == level) begin
            cnt <= 8'd0;
        end else if (cnt >= deb_cfg) begin
            level <= sync2;
            cnt   <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/io_gpio_irq.sv
// GPIO edge interrupt controller on the IO bus read chain.
// Define IO_GPIO_IRQ_DEBOUNCE_EN to add the per-pin debounce filter and DEB_CFG.
module io_gpio_irq (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    input  logic [3:0]  gpio_i,
    output logic        gpio_irq
);

    import io_gpio_irq_pkg::*;

    logic [3:0] irq_en;
    logic [7:0] edge_sel;
    logic [3:0] irq_stat;
    logic [3:0] stat_clr;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] hit;
    logic       wr_en;
    logic       wr_edge;
    logic       wr_stat;
    logic       sel_en;
    logic       sel_edge;
    logic       sel_stat;
    logic       sel_deb;
    logic       unused_ok;

    assign wr_en    = dma_io_we && (dma_io_wadr == ADR_IRQ_EN);
    assign wr_edge  = dma_io_we && (dma_io_wadr == ADR_EDGE_SEL);
    assign wr_stat  = dma_io_we && (dma_io_wadr == ADR_IRQ_STAT);
    assign stat_clr = wr_stat ? dma_io_wdata[3:0] : 4'h0;

`ifdef IO_GPIO_IRQ_DEBOUNCE_EN
    logic [7:0] deb_cfg;
    logic       wr_deb;

    assign wr_deb = dma_io_we && (dma_io_wadr == ADR_DEB_CFG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cfg <= 8'd0;
        end else if (wr_deb) begin
            deb_cfg <= dma_io_wdata[7:0];
        end
    end
`endif

    for (genvar n = 0; n < NUM_PINS; n++) begin : g_pin
        io_gpio_irq_deb u_deb (
            .clk     (clk),
            .rst     (rst),
            .pin     (gpio_i[n]),
`ifdef IO_GPIO_IRQ_DEBOUNCE_EN
            .deb_cfg (deb_cfg),
`endif
            .rise    (rise[n]),
            .fall    (fall[n])
        );
    end

    always_comb begin
        hit = 4'h0;
        for (int n = 0; n < NUM_PINS; n++) begin
            hit[n] = edge_hit(edge_mode_e'(edge_sel[2*n +: 2]), rise[n], fall[n]);
        end
    end

    // A new edge is ORed in after the clear so it is never lost to a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en   <= 4'h0;
            edge_sel <= 8'h00;
            irq_stat <= 4'h0;
        end else begin
            if (wr_en) begin
                irq_en <= dma_io_wdata[3:0];
            end
            if (wr_edge) begin
                edge_sel <= dma_io_wdata[7:0];
            end
            irq_stat <= (irq_stat & ~stat_clr) | hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_en   <= 1'b0;
            sel_edge <= 1'b0;
            sel_stat <= 1'b0;
            sel_deb  <= 1'b0;
        end else begin
            sel_en   <= dma_io_radr_en && (dma_io_radr == ADR_IRQ_EN);
            sel_edge <= dma_io_radr_en && (dma_io_radr == ADR_EDGE_SEL);
            sel_stat <= dma_io_radr_en && (dma_io_radr == ADR_IRQ_STAT);
            sel_deb  <= dma_io_radr_en && (dma_io_radr == ADR_DEB_CFG);
        end
    end

    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        if (sel_en) begin
            dma_io_rdata = {28'h0, irq_en};
        end else if (sel_edge) begin
            dma_io_rdata = {24'h0, edge_sel};
        end else if (sel_stat) begin
            dma_io_rdata = {28'h0, irq_stat};
        end else if (sel_deb) begin
`ifdef IO_GPIO_IRQ_DEBOUNCE_EN
            dma_io_rdata = {24'h0, deb_cfg};
`else
            dma_io_rdata = 32'h0;
`endif
        end
    end

    assign gpio_irq  = |(irq_stat & irq_en);
    assign unused_ok = &{1'b0, dma_io_wdata[31:8]};

endmodule

// File: doc/io_gpio_irq.md
IO_GPIO_IRQ -- requirements
Module: io_gpio_irq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports dma_io_we (in, 1), dma_io_wadr (in, [15:2]), dma_io_wdata (in, 32), the IO-bus write strobe, word address and data.
REQ-004 SHALL have ports dma_io_radr (in, [15:2]) and dma_io_radr_en (in, 1), the IO-bus read address and read enable.
REQ-005 SHALL have port dma_io_rdata_in, input, 32, the read data from the previous chain stage, passed through when not selected.
REQ-006 SHALL have port dma_io_rdata, output, 32, the read data to the next chain stage (the LED/GPIO block's dma_io_rdata_in).
REQ-007 SHALL have port gpio_i, input, 4, raw asynchronous GPIO pin levels.
REQ-008 SHALL have port gpio_irq, output, 1, level interrupt request to the CPU.

Function
REQ-009 SHALL decode word addresses: 14'h3F88 IRQ_EN [3:0] RW; 14'h3F89 EDGE_SEL [7:0] RW; 14'h3F8A IRQ_STAT [3:0] read / write-1-to-clear; 14'h3F8B DEB_CFG [7:0] RW.
REQ-010 SHALL update the written register on the clock edge where dma_io_we=1 and the address matches; other addresses are ignored.
REQ-011 SHALL register the per-register read-select one cycle after dma_io_radr_en with a matching address, and in that cycle drive zero-extended current register contents; otherwise dma_io_rdata = dma_io_rdata_in.
REQ-012 SHALL synchronise each gpio_i bit through two flops before any use.
REQ-013 SHALL, per pin, update the debounced level only after the synchronised level has differed from it for DEB_CFG+1 consecutive cycles; the counter restarts whenever the levels agree.
REQ-014 SHALL detect an edge as a change of the debounced level; EDGE_SEL[2n+1:2n] for pin n: 00 none, 01 rising, 10 falling, 11 both.
REQ-015 SHALL set IRQ_STAT[n] the cycle after a selected edge, regardless of IRQ_EN; bits stay set until cleared.
REQ-016 SHALL clear IRQ_STAT[n] on a write to 14'h3F8A with wdata[n]=1; set SHALL win over clear in the same cycle.
REQ-017 SHALL drive gpio_irq = |(IRQ_STAT & IRQ_EN) combinationally from registers.
REQ-018 SHALL apply a changed DEB_CFG to in-progress counts at once; a running count already >= new threshold commits on the next cycle.
REQ-019 SHALL saturate nothing beyond 8-bit count; maximum filter length is 256 cycles.

Reset
REQ-020 SHALL reset synchroniser flops, debounced levels, counters, IRQ_EN, EDGE_SEL, IRQ_STAT, DEB_CFG and read-select flops to 0; gpio_irq=0 and dma_io_rdata=dma_io_rdata_in during and after reset.
REQ-021 SHALL treat a pin held high through reset release as a rising edge after debounce (IRQ_STAT sets only if EDGE_SEL was enabled by then).
REQ-022 SHALL abort any in-progress debounce or read-select on reset assertion mid-operation.

Configuration
REQ-023 SHALL, when IO_GPIO_IRQ_DEBOUNCE_EN is defined, implement REQ-013 and DEB_CFG as specified.
REQ-024 SHALL, without IO_GPIO_IRQ_DEBOUNCE_EN, use the synchronised level directly as debounced level, read DEB_CFG as 0, ignore its writes, and instantiate no counters.

Structure
REQ-025 SHALL place register word addresses and EDGE_SEL mode encodings in shared package io_gpio_irq_pkg.
REQ-026 SHALL implement per-pin synchroniser plus debounce in sub-module io_gpio_irq_deb, instantiated four times.

Verification
REQ-027 DEB_CFG=0, EDGE_SEL=8'h01, IRQ_EN=1, gpio_i[0] 0->1 -> IRQ_STAT=4'h1 four cycles later, gpio_irq=1.
REQ-028 DEB_CFG=5, 3-cycle glitch on gpio_i[1] -> no status change; 6-cycle stable high with EDGE_SEL=8'h04 -> IRQ_STAT[1]=1.
REQ-029 EDGE_SEL=8'hC0, pin3 pulse high then low -> IRQ_STAT[3] set on both edges; write 4'h8 to 3F8A -> IRQ_STAT=0, gpio_irq=0.
REQ-030 Clear write to 3F8A coinciding with new edge event on same pin -> IRQ_STAT bit remains 1.
REQ-031 Read 3F89 after writing 8'hA5 -> dma_io_rdata=32'h000000A5 one cycle after radr_en; read 3F80 -> dma_io_rdata equals dma_io_rdata_in.
REQ-032 rst asserted mid-debounce with IRQ_STAT=4'hF -> all registers 0, gpio_irq=0 immediately.
